// File: rtl/spi_irq_ctrl.sv
// SPI interrupt controller: sticky pending bits, per-source enable mask and a
// level IRQ that is held low for a re-arm gap after every deassertion.
module spi_irq_ctrl #(
  parameter int NUM_SRC    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CW         = 4
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [NUM_SRC-1:0] wr_data,
  input  logic [1:0]         rd_addr,
  output logic [NUM_SRC-1:0] rd_data,
  output logic               IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] pend_d;
  logic [NUM_SRC-1:0] force_set;
  logic [NUM_SRC-1:0] w1c_clr;
  logic               masked_any;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               irq_q;

  always_comb begin
    force_set = '0;
    w1c_clr   = '0;
    if (wr_en) begin
      case (wr_addr)
        2'd1:    w1c_clr   = wr_data;
        2'd3:    force_set = wr_data;
        default: ;
      endcase
    end
  end

  // Clear is applied before the set so a same-cycle event or force wins.
  assign pend_d     = (pend_q & ~w1c_clr) | evt_i | force_set;
  assign masked_any = |(pend_q & enable_q);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      enable_q <= '0;
      pend_q   <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_en && (wr_addr == 2'd0)) begin
        enable_q <= wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (masked_any) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!masked_any) begin
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // IRQ is a flop decoded from the next state so it only moves on the edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      irq_q   <= (state_d == ST_ASSERT);
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      2'd0:    rd_data = enable_q;
      2'd1:    rd_data = pend_q;
      2'd2:    rd_data = pend_q & enable_q;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_irq_ctrl.sv
// Bench for spi_irq_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural timing model.
module tb_spi_irq_ctrl;

  localparam int NS  = 4;
  localparam int GAP = 2;

  logic          PCLK;
  logic          PRESETn;
  logic [NS-1:0] evt_i;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [NS-1:0] wr_data;
  logic [1:0]    rd_addr;
  logic [NS-1:0] rd_data;
  logic          IRQ;

  spi_irq_ctrl #(.NUM_SRC(NS), .GAP_CYCLES(GAP), .CW(4)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .evt_i   (evt_i),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .IRQ     (IRQ)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;
  int npos  = 0;
  int nneg  = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge IRQ) npos++;
  always @(negedge IRQ) nneg++;

  // Model: registers as a plain read/modify view; IRQ from timing rules:
  // follows masked state while high, and may only rise once it has been low
  // for at least GAP+1 cycles.
  logic [NS-1:0] m_en, m_pend;
  bit            m_irq;
  int            m_low;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_en   = '0;
      m_pend = '0;
      m_irq  = 1'b0;
      m_low  = 1000;
    end else begin
      logic          ma;
      bit            nirq;
      logic [NS-1:0] setv, clrv;
      ma = |(m_pend & m_en);
      if (m_irq) nirq = ma;
      else       nirq = ma && (m_low >= GAP + 1);
      if (nirq)       m_low = 0;
      else if (m_irq) m_low = 1;
      else if (m_low < 1000) m_low = m_low + 1;
      m_irq = nirq;
      setv = evt_i;
      clrv = '0;
      if (wr_en && wr_addr == 2'd3) setv = setv | wr_data;
      if (wr_en && wr_addr == 2'd1) clrv = wr_data;
      for (int i = 0; i < NS; i++) begin
        if (setv[i])      m_pend[i] = 1'b1;
        else if (clrv[i]) m_pend[i] = 1'b0;
      end
      if (wr_en && wr_addr == 2'd0) m_en = wr_data;
    end
  end

  function automatic logic [NS-1:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_en;
      2'd1:    return m_pend;
      2'd2:    return m_pend & m_en;
      default: return '0;
    endcase
  endfunction

  always @(negedge PCLK) begin
    if (run_chk && PRESETn) begin
      chk("irq_model", IRQ, m_irq);
      chk("rd_model", rd_data, model_rd(rd_addr));
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
    evt_i = '0;
    wr_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [NS-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
  endtask

  task automatic pulse(input logic [NS-1:0] e);
    evt_i = e;
    step();
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [NS-1:0] exp);
    rd_addr = a;
    #1;
    chk(nm, rd_data, exp);
  endtask

  initial begin
    PRESETn = 1'b0;
    evt_i   = 4'hF;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_irq", IRQ, 1'b0);
    rd_chk("rst_en", 2'd0, 4'h0);
    rd_chk("rst_pend", 2'd1, 4'h0);
    evt_i = '0;
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    run_chk = 1'b1;
    step();
    step();
    rd_chk("rel_en", 2'd0, 4'h0);
    rd_chk("rel_pend", 2'd1, 4'h0);
    rd_chk("rel_masked", 2'd2, 4'h0);
    chk("rel_irq", IRQ, 1'b0);

    // Basic path and re-arm gap
    wr(2'd0, 4'h1);
    npos = 0;
    nneg = 0;
    pulse(4'h1);
    rd_chk("basic_pend_n1", 2'd1, 4'h1);
    chk("basic_irq_n1", IRQ, 1'b0);
    step();
    chk("basic_irq_n2", IRQ, 1'b1);
    wr(2'd1, 4'h1);
    chk("clr_irq_m1", IRQ, 1'b1);
    rd_chk("clr_pend_m1", 2'd1, 4'h0);
    step();
    chk("clr_irq_m2", IRQ, 1'b0);
    pulse(4'h1);
    chk("gap_low1", IRQ, 1'b0);
    step();
    chk("gap_low2", IRQ, 1'b0);
    step();
    chk("gap_rise", IRQ, 1'b1);
    chk("gap_npos", npos, 2);
    chk("gap_nneg", nneg, 1);
    wr(2'd1, 4'h1);
    step();
    step();
    chk("gap_clr_irq", IRQ, 1'b0);
    repeat (4) step();

    // Masking
    wr(2'd0, 4'h2);
    pulse(4'h4);
    step();
    rd_chk("mask_pend", 2'd1, 4'h4);
    rd_chk("mask_masked", 2'd2, 4'h0);
    chk("mask_irq", IRQ, 1'b0);
    wr(2'd0, 4'h6);
    chk("mask_irq_k1", IRQ, 1'b0);
    step();
    chk("mask_irq_k2", IRQ, 1'b1);

    // Set beats clear
    wr(2'd1, 4'hF);
    wr(2'd0, 4'h8);
    wr(2'd3, 4'h8);
    repeat (4) step();
    chk("sbc_irq_pre", IRQ, 1'b1);
    rd_chk("force_rd0", 2'd3, 4'h0);
    npos = 0;
    nneg = 0;
    wr_en   = 1'b1;
    wr_addr = 2'd1;
    wr_data = 4'h8;
    evt_i   = 4'h8;
    step();
    step();
    step();
    rd_chk("sbc_pend", 2'd1, 4'h8);
    chk("sbc_irq", IRQ, 1'b1);
    chk("sbc_nneg", nneg, 0);
    wr(2'd2, 4'hF);
    rd_chk("masked_wr_en", 2'd0, 4'h8);
    rd_chk("masked_wr_pend", 2'd1, 4'h8);

    // Asynchronous reset while asserted
    PRESETn = 1'b0;
    #1;
    chk("async_irq", IRQ, 1'b0);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    rd_chk("async_en", 2'd0, 4'h0);
    rd_chk("async_pend", 2'd1, 4'h0);
    step();
    chk("async_irq_after", IRQ, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      evt_i = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 5) == 0) begin
        wr_en   = 1'b1;
        wr_addr = 2'($urandom);
        wr_data = 4'($urandom);
      end
      rd_addr = 2'($urandom);
      step();
    end

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
